// File: rtl/reaction_ctrl.sv
// Reaction-timer game controller.
// Start arms a pseudo-random pre-LED delay, the LED then lights and the
// response time is counted in two BCD digits of 10 ms ticks. False starts,
// timeouts at 99 and a best-time register are handled here; the BCD outputs
// feed the existing seven-segment decoders directly.
module reaction_ctrl #(
   parameter int         MIN_TICKS = 100,
   parameter int         RAND_BITS = 6,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       c9,
   input  logic       Start,
   input  logic       Pushn,
   output logic       LEDn,
   output logic [3:0] BCD1,
   output logic [3:0] BCD0,
   output logic [3:0] Best1,
   output logic [3:0] Best0,
   output logic       FalseStart,
   output logic       Timeout,
   output logic       Busy
);

   // Wide enough for the largest delay, MIN_TICKS + 2^RAND_BITS - 1.
   localparam int DLY_W = $clog2(MIN_TICKS + 2**RAND_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ARMED,
      S_DONE,
      S_FAULT
   } state_t;

   state_t             state;
   logic [7:0]         lfsr;
   logic [DLY_W-1:0]   delay_cnt;
   logic [DLY_W-1:0]   delay_load;
   logic               start_ok;
   logic               count_at_max;
   logic               beats_best;

   // Delay drawn from the LFSR value present before the Start edge.
   assign delay_load   = DLY_W'(MIN_TICKS) + DLY_W'(lfsr[RAND_BITS-1:0]);
   // A held button blocks a new run until it is released.
   assign start_ok     = Start & Pushn;
   assign count_at_max = (BCD1 == 4'd9) && (BCD0 == 4'd9);
   // Packed BCD digits compare correctly as plain binary, tens first.
   assign beats_best   = {BCD1, BCD0} < {Best1, Best0};

   // Free-running 8-bit Fibonacci LFSR supplying the random delay bits.
   always_ff @(posedge Clock) begin
      // NOTE: every clocked assignment is non-blocking so that all registers
      // sample pre-edge values and simulation matches the synthesized flops.
      if (Reset) lfsr <= LFSR_SEED;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   // Game sequencer; every output is a register updated on its transitions.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= S_IDLE;
         LEDn       <= 1'b1;
         BCD1       <= 4'd0;
         BCD0       <= 4'd0;
         Best1      <= 4'd9;
         Best0      <= 4'd9;
         FalseStart <= 1'b0;
         Timeout    <= 1'b0;
         Busy       <= 1'b0;
         delay_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_FAULT: begin
               if (start_ok) begin
                  state      <= S_WAIT;
                  delay_cnt  <= delay_load;
                  BCD1       <= 4'd0;
                  BCD0       <= 4'd0;
                  FalseStart <= 1'b0;
                  Timeout    <= 1'b0;
                  Busy       <= 1'b1;
                  LEDn       <= 1'b1;
               end
            end

            S_WAIT: begin
               if (!Pushn) begin
                  // Pressing before the LED wins over a same-cycle expiry.
                  state      <= S_FAULT;
                  FalseStart <= 1'b1;
                  Busy       <= 1'b0;
                  BCD1       <= 4'd0;
                  BCD0       <= 4'd0;
               end else if (c9) begin
                  delay_cnt <= delay_cnt - DLY_W'(1);
                  if (delay_cnt == DLY_W'(1)) begin
                     state <= S_ARMED;
                     LEDn  <= 1'b0;
                  end
               end
            end

            S_ARMED: begin
               if (!Pushn) begin
                  // Count freezes at its pre-edge value; a coincident tick is dropped.
                  state <= S_DONE;
                  LEDn  <= 1'b1;
                  Busy  <= 1'b0;
                  if (beats_best) begin
                     Best1 <= BCD1;
                     Best0 <= BCD0;
                  end
               end else if (c9) begin
                  if (count_at_max) begin
                     state   <= S_DONE;
                     Timeout <= 1'b1;
                     LEDn    <= 1'b1;
                     Busy    <= 1'b0;
                  end else if (BCD0 == 4'd9) begin
                     BCD0 <= 4'd0;
                     BCD1 <= BCD1 + 4'd1;
                  end else begin
                     BCD0 <= BCD0 + 4'd1;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
               LEDn  <= 1'b1;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl: directed scenarios with literal
// expectations plus randomized play, all compared every cycle against an
// integer-level model of the game rules.
module tb_reaction_ctrl;

   localparam int         MIN_TICKS = 100;
   localparam int         RAND_BITS = 6;
   localparam logic [7:0] SEED      = 8'hA5;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       c9    = 1'b0;
   logic       Start = 1'b0;
   logic       Pushn = 1'b1;
   logic       LEDn;
   logic [3:0] BCD1, BCD0, Best1, Best0;
   logic       FalseStart, Timeout, Busy;

   reaction_ctrl #(
      .MIN_TICKS (MIN_TICKS),
      .RAND_BITS (RAND_BITS),
      .LFSR_SEED (SEED)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .c9         (c9),
      .Start      (Start),
      .Pushn      (Pushn),
      .LEDn       (LEDn),
      .BCD1       (BCD1),
      .BCD0       (BCD0),
      .Best1      (Best1),
      .Best0      (Best0),
      .FalseStart (FalseStart),
      .Timeout    (Timeout),
      .Busy       (Busy)
   );

   always #5 Clock = ~Clock;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // ---------------- behavioural model ----------------
   typedef enum int {M_IDLE, M_WAIT, M_ARMED, M_DONE, M_FAULT} mode_t;
   mode_t      m_mode    = M_IDLE;
   int         m_delay   = 0;
   int         m_count   = 0;
   int         m_best    = 99;
   bit         m_false   = 1'b0;
   bit         m_timeout = 1'b0;
   logic [7:0] m_lfsr    = SEED;

   // Feedback = parity of taps 7,5,4,3.
   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], ^(q & 8'hB8)};
   endfunction

   task automatic model_step(input bit r, input bit s, input bit p, input bit c);
      logic [7:0] pre;
      pre    = m_lfsr;
      m_lfsr = r ? SEED : lfsr_next(m_lfsr);
      if (r) begin
         m_mode = M_IDLE; m_delay = 0; m_count = 0; m_best = 99;
         m_false = 1'b0; m_timeout = 1'b0;
         return;
      end
      case (m_mode)
         M_WAIT: begin
            if (!p) begin
               m_mode = M_FAULT; m_false = 1'b1; m_count = 0;
            end else if (c) begin
               m_delay = m_delay - 1;
               if (m_delay == 0) m_mode = M_ARMED;
            end
         end
         M_ARMED: begin
            if (!p) begin
               m_mode = M_DONE;
               if (m_count < m_best) m_best = m_count;
            end else if (c) begin
               if (m_count == 99) begin
                  m_mode = M_DONE; m_timeout = 1'b1;
               end else begin
                  m_count = m_count + 1;
               end
            end
         end
         default: begin
            if (s && p) begin
               m_mode = M_WAIT;
               m_delay = MIN_TICKS + int'(pre % (8'(1) << RAND_BITS));
               m_count = 0; m_false = 1'b0; m_timeout = 1'b0;
            end
         end
      endcase
   endtask

   function automatic logic [19:0] model_outs();
      return {m_mode != M_ARMED,
              4'(m_count / 10), 4'(m_count % 10),
              4'(m_best / 10),  4'(m_best % 10),
              m_false, m_timeout,
              (m_mode == M_WAIT) || (m_mode == M_ARMED)};
   endfunction

   function automatic logic [19:0] dut_outs();
      return {LEDn, BCD1, BCD0, Best1, Best0, FalseStart, Timeout, Busy};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Single per-cycle comparison of all outputs, away from the active edge.
   always @(negedge Clock) begin
      if (chk_en) check("cycle_outputs", 32'(dut_outs()), 32'(model_outs()));
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycle(input bit r, input bit s, input bit p, input bit c);
      Reset = r; Start = s; Pushn = p; c9 = c;
      @(posedge Clock);
      model_step(r, s, p, c);
      @(negedge Clock);
   endtask

   // n ticks of c9, one pulse every 4 clocks, button released.
   task automatic ticks(input int n);
      repeat (n) begin
         repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
         cycle(1'b0, 1'b0, 1'b1, 1'b1);
      end
   endtask

   task automatic do_start();
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic press_release();
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Count c9 ticks until the LED lights, with a bounded budget.
   task automatic wait_armed(output int n);
      n = 0;
      while (LEDn !== 1'b0 && n < 300) begin
         ticks(1);
         n++;
      end
      if (LEDn !== 1'b0) check("arm_bound", 32'(LEDn), 32'h0);
   endtask

   task automatic run_and_check(input int k, input logic [7:0] exp_best);
      int n;
      do_start();
      wait_armed(n);
      ticks(k);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("run_best", 32'({Best1, Best0}), 32'(exp_best));
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, L, press_len;
      bit r, s, p, c;

      // Model self-pin: one hand-computed LFSR step from the seed.
      check("lfsr_ref_step", 32'(lfsr_next(8'hA5)), 32'h4A);

      // Reset then idle.
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      chk_en = 1'b1;
      for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 1'b1, 1'(i % 4 == 3));
      check("idle_led",  32'(LEDn), 32'h1);
      check("idle_bcd",  32'({BCD1, BCD0}), 32'h00);
      check("idle_best", 32'({Best1, Best0}), 32'h99);
      check("idle_busy", 32'(Busy), 32'h0);
      check("idle_fs",   32'(FalseStart), 32'h0);

      // First run: LED after 100+L ticks, press after 23 more.
      L = int'(m_lfsr[RAND_BITS-1:0]);
      do_start();
      check("wait_busy", 32'(Busy), 32'h1);
      wait_armed(n);
      check("delay_ticks", 32'(n), 32'(MIN_TICKS + L));
      ticks(23);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("run23_bcd",  32'({BCD1, BCD0}), 32'h23);
      check("run23_best", 32'({Best1, Best0}), 32'h23);
      check("run23_busy", 32'(Busy), 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // False start at tick 10.
      do_start();
      ticks(10);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("fault_fs",  32'(FalseStart), 32'h1);
      check("fault_led", 32'(LEDn), 32'h1);
      check("fault_bcd", 32'({BCD1, BCD0}), 32'h00);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      do_start();
      check("restart_fs",   32'(FalseStart), 32'h0);
      check("restart_busy", 32'(Busy), 32'h1);

      // No press: saturate at 99, then time out.
      wait_armed(n);
      ticks(99);
      check("sat_bcd", 32'({BCD1, BCD0}), 32'h99);
      check("sat_led", 32'(LEDn), 32'h0);
      ticks(1);
      check("to_flag", 32'(Timeout), 32'h1);
      check("to_bcd",  32'({BCD1, BCD0}), 32'h99);
      check("to_best", 32'({Best1, Best0}), 32'h23);
      check("to_busy", 32'(Busy), 32'h0);

      // Best tracking from a fresh reset.
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      run_and_check(41, 8'h41);
      run_and_check(17, 8'h17);
      run_and_check(17, 8'h17);
      do_start();
      wait_armed(n);
      ticks(16);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check("coinc_bcd",  32'({BCD1, BCD0}), 32'h16);
      check("coinc_best", 32'({Best1, Best0}), 32'h16);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Reset in the middle of ARMED at count 35.
      do_start();
      wait_armed(n);
      ticks(35);
      check("mid_bcd", 32'({BCD1, BCD0}), 32'h35);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      check("rst_led",  32'(LEDn), 32'h1);
      check("rst_bcd",  32'({BCD1, BCD0}), 32'h00);
      check("rst_best", 32'({Best1, Best0}), 32'h99);
      check("rst_busy", 32'(Busy), 32'h0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'(i % 4 == 3));
      check("held_busy", 32'(Busy), 32'h0);
      check("held_led",  32'(LEDn), 32'h1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Randomized episodes: results, timeouts, false starts.
      for (int ep = 0; ep < 12; ep++) begin
         do_start();
         if (ep % 4 == 3) begin
            ticks($urandom_range(0, 60));
         end else begin
            wait_armed(n);
            k = $urandom_range(0, 105);
            ticks(k);
         end
         repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 1'b1, 1'b0);
         cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
         cycle(1'b0, 1'b0, 1'b1, 1'b0);
      end

      // Free-running random play.
      press_len = 0;
      for (int i = 0; i < 6000; i++) begin
         r = ($urandom_range(0, 1999) == 0);
         s = ($urandom_range(0, 15) == 0);
         if (press_len == 0 && $urandom_range(0, 299) == 0)
            press_len = $urandom_range(1, 4);
         p = (press_len == 0);
         if (press_len > 0) press_len--;
         c = 1'($urandom_range(0, 1));
         cycle(r, s, p, c);
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
